// File: rtl/isr_sequencer_if.sv
// isr_sequencer_if
//   Groups the interrupt-controller / PC-register side signals of the
//   interrupt sequencer. Clock and reset stay plain ports on the modules.
//   slave  : the sequencer (consumes controller/core inputs, drives PC/controls)
//   master : the surrounding core / interrupt controller (or a testbench)
//   Inputs to sequencer : i_pending, isr_vec[7:0], pc_ret[7:0], instr_done,
//                         reti, ei, di
//   Outputs of sequencer: itr_en, itr_clr, pc_load, pc_next[7:0], in_isr,
//                         depth[2:0], stack_err
interface isr_sequencer_if;
    logic       i_pending;
    logic [7:0] isr_vec;
    logic [7:0] pc_ret;
    logic       instr_done;
    logic       reti;
    logic       ei;
    logic       di;
    logic       itr_en;
    logic       itr_clr;
    logic       pc_load;
    logic [7:0] pc_next;
    logic       in_isr;
    logic [2:0] depth;
    logic       stack_err;

    modport slave (
        input  i_pending, isr_vec, pc_ret, instr_done, reti, ei, di,
        output itr_en, itr_clr, pc_load, pc_next, in_isr, depth, stack_err
    );

    modport master (
        output i_pending, isr_vec, pc_ret, instr_done, reti, ei, di,
        input  itr_en, itr_clr, pc_load, pc_next, in_isr, depth, stack_err
    );
endinterface

// File: rtl/isr_sequencer.sv
// isr_sequencer
//   CPU-side interrupt sequencer. At instruction boundaries it either returns
//   from an ISR (pop saved PC, one-cycle PC load) or enters one (push the
//   resume PC, one-cycle PC load of the controller's vector plus a one-cycle
//   clear of the controller's pending latch). Also owns the global interrupt
//   enable and drives the controller's enable.
//   Ports: clk  - clock, all state on rising edge
//          clr  - synchronous active-low reset
//          bus  - isr_sequencer_if.slave (see interface header for signals)
//   Parameter: DEPTH - return-stack entries, used only with nesting.
//   Build option: define ISR_NEST_EN for a DEPTH-entry return stack that
//   accepts interrupts inside an ISR; otherwise a single return register and
//   no nesting.
module isr_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                clr,
    isr_sequencer_if.slave      bus
);

`ifdef ISR_NEST_EN
    localparam int SLOTS = DEPTH;
`else
    // Single return register; DEPTH has no effect in this build.
    localparam int SLOTS = 1 + 0 * DEPTH;
`endif

    typedef enum logic [1:0] {RUN, VECT, RET} state_t;

    state_t     state_q, state_d;
    logic       gie_q, gie_d;
    logic [2:0] depth_q, depth_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] ret_q, ret_d;
    logic       err_q, err_d;
    logic [7:0] stack_q [SLOTS];
    logic [7:0] stack_d [SLOTS];
    logic       en;

    // Enable never allows a push onto a full stack, so the "taken at full
    // stack" error cannot arise through this path.
    assign en            = gie_q & (depth_q < 3'(SLOTS));
    assign bus.itr_en    = en;
    assign bus.itr_clr   = (state_q == VECT);
    assign bus.pc_load   = (state_q == VECT) | (state_q == RET);
    assign bus.pc_next   = (state_q == VECT) ? vec_q :
                           (state_q == RET)  ? ret_q : 8'h00;
    assign bus.in_isr    = (depth_q != 3'd0);
    assign bus.depth     = depth_q;
    assign bus.stack_err = err_q;

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        vec_d   = vec_q;
        ret_d   = ret_q;
        err_d   = err_q;
        stack_d = stack_q;
        gie_d   = bus.di ? 1'b0 : (bus.ei ? 1'b1 : gie_q);

        case (state_q)
            RUN: begin
                if (bus.instr_done && bus.reti) begin
                    // A reti boundary never takes an interrupt; a pending one
                    // is picked up at the next boundary.
                    if (depth_q != 3'd0) begin
                        for (int i = 0; i < SLOTS; i++)
                            if (3'(i) == depth_q - 3'd1) ret_d = stack_q[i];
                        depth_d = depth_q - 3'd1;
                        state_d = RET;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.instr_done && bus.i_pending && en) begin
                    for (int i = 0; i < SLOTS; i++)
                        if (3'(i) == depth_q) stack_d[i] = bus.pc_ret;
                    vec_d   = bus.isr_vec;
                    depth_d = depth_q + 3'd1;
                    state_d = VECT;
                end
            end
            VECT:    state_d = RUN;
            RET:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= RUN;
            gie_q   <= 1'b0;
            depth_q <= 3'd0;
            vec_q   <= 8'h00;
            ret_q   <= 8'h00;
            err_q   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) stack_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            gie_q   <= gie_d;
            depth_q <= depth_d;
            vec_q   <= vec_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

endmodule

// File: tb/tb_isr_sequencer.sv
// tb_isr_sequencer
//   Directed steps from the test plan followed by random stimulus, all checked
//   every cycle against a queue-based reference model of the sequencer.
module tb_isr_sequencer;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    isr_sequencer_if bus();

    isr_sequencer #(.DEPTH(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

`ifdef ISR_NEST_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    // Reference model: return addresses as a queue, load happening this cycle.
    bit         m_gie;
    logic [7:0] m_stk[$];
    bit         m_ld;
    bit         m_cp;
    logic [7:0] m_val;
    bit         m_err;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit         en;
        bit         ld;
        bit         cp;
        logic [7:0] v;
        en = m_gie && (m_stk.size() < CAP);
        ld = 0; cp = 0; v = 8'h00;
        if (!clr) begin
            m_gie = 0; m_stk.delete(); m_err = 0;
        end else begin
            if (!m_ld && bus.instr_done) begin
                if (bus.reti) begin
                    if (m_stk.size() > 0) begin
                        ld = 1; v = m_stk.pop_back();
                    end else m_err = 1;
                end else if (bus.i_pending && en) begin
                    m_stk.push_back(bus.pc_ret);
                    ld = 1; cp = 1; v = bus.isr_vec;
                end
            end
            if (bus.di) m_gie = 0;
            else if (bus.ei) m_gie = 1;
        end
        m_ld = ld; m_cp = cp; m_val = v;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("itr_en",    8'(bus.itr_en),    8'(m_gie && (m_stk.size() < CAP)));
        chk("itr_clr",   8'(bus.itr_clr),   8'(m_cp));
        chk("pc_load",   8'(bus.pc_load),   8'(m_ld));
        chk("pc_next",   bus.pc_next,       m_ld ? m_val : 8'h00);
        chk("depth",     8'(bus.depth),     8'(m_stk.size()));
        chk("in_isr",    8'(bus.in_isr),    8'(m_stk.size() != 0));
        chk("stack_err", 8'(bus.stack_err), 8'(m_err));
    endtask

    task automatic drive(input bit done, input bit rt, input bit pend,
                         input logic [7:0] vec, input logic [7:0] pcr,
                         input bit e, input bit d);
        bus.instr_done = done; bus.reti = rt; bus.i_pending = pend;
        bus.isr_vec = vec; bus.pc_ret = pcr; bus.ei = e; bus.di = d;
    endtask

    initial begin
        logic [7:0] vecs [4];
        logic [7:0] pcs  [4];
        vecs = '{8'hC8, 8'hD7, 8'hE6, 8'hF5};
        pcs  = '{8'h10, 8'h20, 8'h30, 8'h40};
        m_gie = 0; m_ld = 0; m_cp = 0; m_val = 0; m_err = 0;

        // Reset
        clr = 0; drive(0, 0, 0, 8'h00, 8'h00, 0, 0);
        cycle(); cycle();
        chk("rst_depth", 8'(bus.depth), 8'h00);
        clr = 1; cycle();

        // Enable, then enter ISR at C8 from 12
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0); cycle();
        drive(1, 0, 1, 8'hC8, 8'h12, 0, 0); cycle();
        chk("entry_pc", bus.pc_next, 8'hC8);
        chk("entry_clr", 8'(bus.itr_clr), 8'h01);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();

        // Return to 12
        drive(1, 1, 0, 8'h00, 8'h00, 0, 0); cycle();
        chk("ret_pc", bus.pc_next, 8'h12);
        chk("ret_en", 8'(bus.itr_en), 8'h01);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();

        // reti beats a pending interrupt on the same boundary
        drive(1, 0, 1, 8'hC8, 8'h34, 0, 0); cycle();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();
        drive(1, 1, 1, 8'hD7, 8'h50, 0, 0); cycle();
        chk("prio_ret", bus.pc_next, 8'h34);
        drive(0, 0, 1, 8'hD7, 8'h56, 0, 0); cycle();
        drive(1, 0, 1, 8'hD7, 8'h56, 0, 0); cycle();
        chk("prio_vec", bus.pc_next, 8'hD7);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();
        drive(1, 1, 0, 8'h00, 8'h00, 0, 0); cycle();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();

`ifdef ISR_NEST_EN
        // Nest four deep, then unwind in LIFO order
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, vecs[i], pcs[i], 0, 0); cycle();
            chk("nest_vec", bus.pc_next, vecs[i]);
            drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();
        end
        chk("nest_depth", 8'(bus.depth), 8'h04);
        chk("nest_en", 8'(bus.itr_en), 8'h00);
        for (int i = 3; i >= 0; i--) begin
            drive(1, 1, 0, 8'h00, 8'h00, 0, 0); cycle();
            chk("unwind_pc", bus.pc_next, pcs[i]);
            drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();
        end
`else
        // Single level: a second interrupt is refused inside the ISR
        drive(1, 0, 1, vecs[0], pcs[0], 0, 0); cycle();
        drive(1, 0, 1, vecs[1], pcs[1], 0, 0); cycle();
        chk("nonest_en", 8'(bus.itr_en), 8'h00);
        chk("nonest_load", 8'(bus.pc_load), 8'h00);
        drive(1, 1, 0, 8'h00, 8'h00, 0, 0); cycle();
        chk("nonest_ret", bus.pc_next, pcs[0]);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle();
`endif

        // reti at depth 0: error, no load, sticky
        drive(1, 1, 0, 8'h00, 8'h00, 0, 0); cycle();
        chk("uflow_load", 8'(bus.pc_load), 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0); cycle(); cycle(); cycle();
        chk("uflow_sticky", 8'(bus.stack_err), 8'h01);

        // ei and di together: di wins
        drive(0, 0, 0, 8'h00, 8'h00, 1, 1); cycle();
        chk("di_wins", 8'(bus.itr_en), 8'h00);

        // Reset in the middle of VECT
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0); cycle();
        drive(1, 0, 1, 8'hA5, 8'h66, 0, 0); cycle();
        clr = 0; drive(0, 0, 1, 8'hA5, 8'h66, 0, 0); cycle();
        chk("rst_vect_load", 8'(bus.pc_load), 8'h00);
        chk("rst_vect_err", 8'(bus.stack_err), 8'h00);
        clr = 1; drive(1, 0, 1, 8'hA5, 8'h66, 0, 0); cycle();
        chk("gie_off_load", 8'(bus.pc_load), 8'h00);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            clr = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
